// File: rtl/uart_rx_framer.sv
// UART receiver/deframer: 8N1, LSB first, oversampled at CLKS_PER_BIT clocks
// per bit. A completed byte is held in rx_data under a valid/ready handshake.
// Frame errors and dropped bytes are reported as one-cycle pulses.
module uart_rx_framer #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       RxD,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } state_t;

   state_t        state, state_nxt;
   logic          rx_meta, rxs;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          half_tick, bit_tick, sample_bit, deliver, stop_bad;

   // Two-flop synchronizer; resets to the idle (high) line level
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= RxD;
         rxs     <= rx_meta;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (!rxs) state_nxt = START;
         START:     if (half_tick) state_nxt = rxs ? IDLE : DATA;
         DATA:      if (bit_tick && bit_idx == 3'd7) state_nxt = STOP;
         STOP:      if (bit_tick) state_nxt = rxs ? IDLE : WAIT_IDLE;
         WAIT_IDLE: if (rxs) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Decoded sampling strobes and output events
   always_comb begin
      half_tick  = (state == START) && (cnt == HALF_LAST);
      bit_tick   = (cnt == BIT_LAST);
      sample_bit = (state == DATA) && bit_tick;
      deliver    = (state == STOP) && bit_tick && rxs;
      stop_bad   = (state == STOP) && bit_tick && !rxs;
   end

   // Bit-period counter, bit index and data shift register
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         case (state)
            START:     cnt <= half_tick ? '0 : cnt + CW'(1);
            DATA,
            STOP:      cnt <= bit_tick ? '0 : cnt + CW'(1);
            default: begin
               cnt     <= '0;
               bit_idx <= '0;
            end
         endcase
         if (sample_bit) begin
            shreg[bit_idx] <= rxs;
            bit_idx        <= bit_idx + 3'd1;
         end
      end
   end

   // Output holding register with handshake, overrun and frame-error pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= stop_bad;
         overrun   <= deliver && rx_valid && !rx_ready;
         if (deliver && (!rx_valid || rx_ready)) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer at 16 clocks per bit. A passive
// monitor records accepted bytes and pulse counts; each test compares them
// against the outcome expected from the frames it sent.
module tb_uart_rx_framer;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       RxD = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic       frame_err;
   logic       overrun;

   int n_cmp = 0;
   int n_bad = 0;

   // Monitor state (written only by the monitor process)
   logic [7:0] got[$];
   int         mon_valid = 0;
   int         mon_ferr = 0;
   int         mon_ovr = 0;

   uart_rx_framer #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk),
      .reset(reset),
      .RxD(RxD),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .rx_ready(rx_ready),
      .frame_err(frame_err),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Sample outputs on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (rx_valid) mon_valid++;
      if (rx_valid && rx_ready) got.push_back(rx_data);
      if (frame_err) mon_ferr++;
      if (overrun) mon_ovr++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drive the first n bits of pat (bit 0 first), one bit period each
   task automatic drive_bits(input logic [9:0] pat, input int n);
      for (int k = 0; k < n; k++) begin
         if (k == 0) @(posedge clk);
         else repeat (CPB) @(posedge clk);
         #1 RxD = pat[k];
      end
      repeat (CPB) @(posedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input int idle);
      drive_bits({stop, b, 1'b0}, 10);
      #1 RxD = 1'b1;
      repeat (idle) @(posedge clk);
   endtask

   task automatic drain();
      @(posedge clk);
      #1 rx_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
      n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", rx_data); end
      n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
      n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_ovr: got %b want 0", overrun); end
      reset = 1'b0;
      repeat (5) @(posedge clk);
   endtask

   task automatic test_single();
      int g0, v0, f0, o0;
      rx_ready = 1'b1;
      g0 = got.size(); v0 = mon_valid; f0 = mon_ferr; o0 = mon_ovr;
      send_frame(8'h41, 1'b1, 20);
      n_cmp++; if (mon_valid - v0 != 1) begin n_bad++; $display("FAIL single_valid_cycles: got %0d want 1", mon_valid - v0); end
      n_cmp++; if (got.size() - g0 != 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", got.size() - g0); end
      else begin
         n_cmp++; if (got[g0] !== 8'h41) begin n_bad++; $display("FAIL single_data: got %h want 41", got[g0]); end
      end
      n_cmp++; if (mon_ferr - f0 != 0) begin n_bad++; $display("FAIL single_ferr: got %0d want 0", mon_ferr - f0); end
      n_cmp++; if (mon_ovr - o0 != 0) begin n_bad++; $display("FAIL single_ovr: got %0d want 0", mon_ovr - o0); end
   endtask

   task automatic test_random();
      logic [7:0] exp_q[$];
      int exp_ferr = 0;
      int g0, f0, o0;
      logic [7:0] b;
      logic st;
      rx_ready = 1'b1;
      g0 = got.size(); f0 = mon_ferr; o0 = mon_ovr;
      for (int i = 0; i < 10; i++) begin
         b  = 8'($urandom_range(0, 255));
         st = (i == 3) ? 1'b0 : ($urandom_range(0, 3) != 0);
         if (st) exp_q.push_back(b);
         else exp_ferr++;
         send_frame(b, st, $urandom_range(4, 30));
      end
      repeat (5) @(posedge clk);
      n_cmp++; if (got.size() - g0 != exp_q.size()) begin n_bad++; $display("FAIL rand_count: got %0d want %0d", got.size() - g0, exp_q.size()); end
      else begin
         foreach (exp_q[i]) begin
            n_cmp++; if (got[g0 + i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_data[%0d]: got %h want %h", i, got[g0 + i], exp_q[i]); end
         end
      end
      n_cmp++; if (mon_ferr - f0 != exp_ferr) begin n_bad++; $display("FAIL rand_ferr: got %0d want %0d", mon_ferr - f0, exp_ferr); end
      n_cmp++; if (mon_ovr - o0 != 0) begin n_bad++; $display("FAIL rand_ovr: got %0d want 0", mon_ovr - o0); end
   endtask

   task automatic test_glitch();
      int g0, f0, v0;
      rx_ready = 1'b1;
      g0 = got.size(); f0 = mon_ferr; v0 = mon_valid;
      @(posedge clk);
      #1 RxD = 1'b0;
      repeat (5) @(posedge clk);
      #1 RxD = 1'b1;
      repeat (40) @(posedge clk);
      n_cmp++; if (mon_valid - v0 != 0) begin n_bad++; $display("FAIL glitch_valid: got %0d want 0", mon_valid - v0); end
      n_cmp++; if (mon_ferr - f0 != 0) begin n_bad++; $display("FAIL glitch_ferr: got %0d want 0", mon_ferr - f0); end
      send_frame(8'hA5, 1'b1, 10);
      n_cmp++; if (got.size() - g0 != 1 || got[got.size() - 1] !== 8'hA5) begin n_bad++; $display("FAIL glitch_next: got %0d bytes, last %h want 1 byte A5", got.size() - g0, got[got.size() - 1]); end
   endtask

   task automatic test_frame_err();
      int g0, f0, v0;
      rx_ready = 1'b1;
      g0 = got.size(); f0 = mon_ferr; v0 = mon_valid;
      send_frame(8'h55, 1'b0, 20);
      n_cmp++; if (mon_ferr - f0 != 1) begin n_bad++; $display("FAIL ferr_count: got %0d want 1", mon_ferr - f0); end
      n_cmp++; if (mon_valid - v0 != 0) begin n_bad++; $display("FAIL ferr_valid: got %0d want 0", mon_valid - v0); end
      // Break: line held low for many bit times
      f0 = mon_ferr;
      @(posedge clk);
      #1 RxD = 1'b0;
      repeat (40 * CPB) @(posedge clk);
      #1 RxD = 1'b1;
      repeat (20) @(posedge clk);
      n_cmp++; if (mon_ferr - f0 != 1) begin n_bad++; $display("FAIL break_ferr: got %0d want 1", mon_ferr - f0); end
      send_frame(8'h0F, 1'b1, 10);
      n_cmp++; if (got.size() - g0 != 1 || got[got.size() - 1] !== 8'h0F) begin n_bad++; $display("FAIL ferr_next: got %0d bytes, last %h want 1 byte 0F", got.size() - g0, got[got.size() - 1]); end
   endtask

   task automatic test_back_to_back();
      int g0, o0;
      drain();
      rx_ready = 1'b0;
      g0 = got.size(); o0 = mon_ovr;
      send_frame(8'h41, 1'b1, 0);
      send_frame(8'h42, 1'b1, 10);
      n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid: got %b want 1", rx_valid); end
      n_cmp++; if (rx_data !== 8'h41) begin n_bad++; $display("FAIL b2b_data: got %h want 41", rx_data); end
      n_cmp++; if (mon_ovr - o0 != 1) begin n_bad++; $display("FAIL b2b_ovr: got %0d want 1", mon_ovr - o0); end
      @(posedge clk);
      #1 rx_ready = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_fall: got %b want 0", rx_valid); end
      n_cmp++; if (got.size() - g0 != 1 || got[got.size() - 1] !== 8'h41) begin n_bad++; $display("FAIL b2b_take: got %0d bytes, last %h want 1 byte 41", got.size() - g0, got[got.size() - 1]); end
   endtask

   task automatic test_coincide();
      int g0, o0;
      drain();
      rx_ready = 1'b0;
      send_frame(8'h41, 1'b1, 4);
      g0 = got.size(); o0 = mon_ovr;
      // Stop-bit sample lands 155 clocks after the frame's first edge
      fork
         send_frame(8'h42, 1'b1, 10);
         begin
            @(posedge clk);
            repeat (154) @(posedge clk);
            #1 rx_ready = 1'b1;
            @(posedge clk);
            #1 rx_ready = 1'b0;
         end
      join
      n_cmp++; if (got.size() - g0 != 1 || got[got.size() - 1] !== 8'h41) begin n_bad++; $display("FAIL coin_take: got %0d bytes, last %h want 1 byte 41", got.size() - g0, got[got.size() - 1]); end
      n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL coin_valid: got %b want 1", rx_valid); end
      n_cmp++; if (rx_data !== 8'h42) begin n_bad++; $display("FAIL coin_data: got %h want 42", rx_data); end
      n_cmp++; if (mon_ovr - o0 != 0) begin n_bad++; $display("FAIL coin_ovr: got %0d want 0", mon_ovr - o0); end
   endtask

   task automatic test_reset_mid();
      int g0, f0, o0, v0;
      drain();
      rx_ready = 1'b0;
      send_frame(8'h99, 1'b1, 4);
      drive_bits({1'b1, 8'hC3, 1'b0}, 5);
      #1 reset = 1'b1;
      RxD = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %b want 0", rx_valid); end
      n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL rmid_data: got %h want 00", rx_data); end
      reset = 1'b0;
      g0 = got.size(); f0 = mon_ferr; o0 = mon_ovr; v0 = mon_valid;
      repeat (12 * CPB) @(posedge clk);
      n_cmp++; if (mon_ferr - f0 != 0 || mon_ovr - o0 != 0 || mon_valid - v0 != 0) begin n_bad++; $display("FAIL rmid_quiet: got ferr %0d ovr %0d valid %0d want 0 0 0", mon_ferr - f0, mon_ovr - o0, mon_valid - v0); end
      rx_ready = 1'b1;
      send_frame(8'h3C, 1'b1, 10);
      n_cmp++; if (got.size() - g0 != 1 || got[got.size() - 1] !== 8'h3C) begin n_bad++; $display("FAIL rmid_next: got %0d bytes, last %h want 1 byte 3C", got.size() - g0, got[got.size() - 1]); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_random();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_coincide();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
